// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the byte-oriented UART blocks.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS          = 8;
  localparam int unsigned UART_DEFAULT_BAUD_DIV   = 868;  // 100 MHz / 115200
  localparam int unsigned UART_DEFAULT_FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an explicit level counter and a registered drop flag.
// Pushes are judged against the pre-edge level, so a push into a full queue is
// dropped even if a pop frees a slot on the same edge.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [$clog2(DEPTH):0]   level_next_c,
  output logic                     drop_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             drop_q, drop_d;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  // Qualify requests and compute next pointers/level.
  always_comb begin
    full     = (level_q == LVL_W'(DEPTH));
    empty_c  = (level_q == '0);
    push_ok  = push_i & ~full;
    pop_ok   = pop_i & ~empty_c;
    drop_d   = push_i & full;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer, level and drop-flag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      drop_q   <= drop_d;
    end
  end

  // Storage array; contents need no reset since the level gates reads.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_c       = mem_q[rd_ptr_q];
  assign level_o      = level_q;
  assign level_next_c = level_d;
  assign drop_o       = drop_q;

endmodule

// File: rtl/out_byte_uart_tx.sv
// 8N1 UART transmitter fed by the CPU's single-byte output strobe through a
// small FIFO. Frames go back-to-back while bytes are queued.
module out_byte_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = UART_DEFAULT_BAUD_DIV,
  parameter int unsigned FIFO_DEPTH = UART_DEFAULT_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [UART_DATA_BITS-1:0]     in_byte,
  input  logic                          in_byte_en,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int unsigned CNT_W = $clog2(BAUD_DIV);
  localparam int unsigned BIT_W = $clog2(UART_DATA_BITS);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] BAUD_LOAD = CNT_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);

  uart_state_e                state_q, state_d;
  logic [CNT_W-1:0]           baud_q, baud_d;
  logic [BIT_W-1:0]           bit_q, bit_d;
  logic [UART_DATA_BITS-1:0]  shift_q, shift_d;
  logic                       tx_q, tx_d;
  logic                       busy_q, busy_d;
  logic                       pop_c;
  logic                       baud_end_c;
  logic [UART_DATA_BITS-1:0]  fifo_data_c;
  logic                       fifo_empty_c;
  logic [LVL_W-1:0]           fifo_level_next_c;

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i        (clk),
    .rst_ni       (resetn),
    .push_i       (in_byte_en),
    .data_i       (in_byte),
    .pop_i        (pop_c),
    .data_c       (fifo_data_c),
    .empty_c      (fifo_empty_c),
    .level_o      (fifo_level),
    .level_next_c (fifo_level_next_c),
    .drop_o       (overflow)
  );

  // Frame sequencer: next state, baud/bit counters, shifter and pin value.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    pop_c      = 1'b0;
    baud_end_c = (baud_q == '0);

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_c) begin
          pop_c   = 1'b1;
          shift_d = fifo_data_c;
          baud_d  = BAUD_LOAD;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_end_c) begin
          baud_d  = BAUD_LOAD;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q - CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_end_c) begin
          baud_d = BAUD_LOAD;
          if (bit_q == BIT_LAST) begin
            state_d = ST_STOP;
          end else begin
            shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
            bit_d   = bit_q + BIT_W'(1);
          end
        end else begin
          baud_d = baud_q - CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_end_c) begin
          if (!fifo_empty_c) begin
            // Chain straight into the next frame with no idle bit.
            pop_c   = 1'b1;
            shift_d = fifo_data_c;
            baud_d  = BAUD_LOAD;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase

    busy_d = (state_d != ST_IDLE) | (fifo_level_next_c != '0);
  end

  // Sequencer registers; reset forces the line high and abandons any frame.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: doc/out_byte_uart_tx.md
# out_byte_uart_tx

Serial consumer for the CPU's single-byte output port. It accepts the one-cycle `out_byte_en` strobe and its `out_byte` value, queues bytes in a small FIFO, and transmits them as 8N1 UART frames on one pin. It lets firmware console output leave the board without the logic analyser, and it sits next to the memory/IO decoder in `system`.

## Interface
- `BAUD_DIV`, 868: clock cycles per UART bit (100 MHz / 115200); legal range is 2 or more.
- `FIFO_DEPTH`, 16: byte queue depth; must be a power of two, 2 or more.
- `clk`  in  1  system clock; the block uses one clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `in_byte`  in  8  byte to send; sampled only when `in_byte_en` = 1.
- `in_byte_en`  in  1  one-cycle push strobe, driven directly by `out_byte_en[0]`.
- `tx`  out  1  UART serial output; idles high.
- `busy`  out  1  high while the FIFO is non-empty or a frame is in flight.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  number of queued bytes, excluding the byte being shifted.
- `overflow`  out  1  one-cycle pulse when a pushed byte is dropped.

## Operation
- **Push:** a byte is accepted on a rising edge with `in_byte_en` = 1 and `fifo_level` < `FIFO_DEPTH`.
  - Fullness is judged on the pre-edge level.
  - A push into a full FIFO is dropped, even if a pop occurs in the same cycle. `overflow` pulses high in the following cycle.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START when the FIFO is non-empty. That same cycle pops the head byte into an 8-bit shift register and loads the baud counter.
  - START: `tx` = 0 for `BAUD_DIV` cycles → DATA.
  - DATA: `tx` = shift[0], LSB first. Shift right every `BAUD_DIV` cycles. A 3-bit bit counter runs 0..7; after bit 7 → STOP.
  - STOP: `tx` = 1 for `BAUD_DIV` cycles.
  - At the end of STOP: if the FIFO is non-empty, pop and go straight to START (no idle gap); otherwise go to IDLE.
- **Baud counter:** width $clog2(BAUD_DIV). It counts `BAUD_DIV`-1 down to 0, and a bit ends on the cycle the count reaches 0.
- **FIFO pointers:** $clog2(FIFO_DEPTH) bits and wrap naturally. `fifo_level` is a separate up/down counter; a simultaneous push and pop leave it unchanged.
- **`busy`:** `busy` = (state ≠ IDLE) | (`fifo_level` ≠ 0).
- **Reset values:** `tx` = 1, `busy` = 0, `fifo_level` = 0, `overflow` = 0, state = IDLE, pointers = 0.
- **Reset mid-frame:** the frame is aborted and `tx` goes high asynchronously. The FIFO is flushed, and no partial frame resumes after release.
- **Outputs:** `tx` and `overflow` are registered. There are no combinational paths from input to output.

## Timing
- Push at edge N: `fifo_level` = 1 in cycle N+1, where the FSM pops. `tx` is low from cycle N+2.
- A frame is 10×`BAUD_DIV` cycles: start, 8 data bits, stop.
- Back-to-back frames: the next start bit begins in the cycle immediately after the last stop-bit cycle.
- `busy` falls in the cycle after the final stop-bit cycle, when the FIFO is empty.
- Sustained throughput is one byte per 10×`BAUD_DIV` cycles. The CPU must pace its writes or accept drops, which are flagged by `overflow`.

## Structure
- Package `uart_pkg` holds:
  - the state enum (IDLE=0, START=1, DATA=2, STOP=3);
  - `UART_DATA_BITS` = 8;
  - the default-`BAUD_DIV` constant.
- Sub-module `sync_fifo` (parameters `WIDTH`, `DEPTH`) provides the push/pop/level logic and can be reused for a later receive path.
- The top level contains the FSM, the baud counter, the bit counter, and the shift register.

## Test plan
All scenarios run with `BAUD_DIV` = 4 and `FIFO_DEPTH` = 4.
- **Single byte:** push 0xA5 at cycle 10.
  - `tx` low in cycles 12–15.
  - Data bits 1,0,1,0,0,1,0,1, each 4 cycles, in cycles 16–47.
  - Stop bit high in cycles 48–51.
  - `busy` high from cycle 11; `busy` low at cycle 52.
- **Back-to-back:** push 0x00 at cycle 10 and 0xFF at cycle 11.
  - Second start bit in cycles 52–55, with no idle cycle.
  - `tx` high for all of cycles 56–91.
- **Overflow:** push 0x01..0x06 in cycles 10–15.
  - `fifo_level` reaches 4 at cycle 15.
  - 0x06 is dropped and `overflow` is high only in cycle 16.
  - Exactly 5 frames are sent: 0x01..0x05.
- **Push while full with concurrent pop:** fill the FIFO while a frame is in STOP, then push on the STOP→START pop edge.
  - The byte is dropped and `overflow` pulses.
  - `fifo_level` becomes 3.
- **Reset mid-frame:** assert `resetn` = 0 during DATA bit 3 with 2 bytes queued.
  - `tx` = 1 and `fifo_level` = 0 immediately.
  - After release, `tx` stays high and `busy` stays 0 for 100 cycles.
- **Idle wrap:** send 9 single bytes spaced 50 cycles apart, so the pointers wrap twice.
  - All 9 bytes arrive in order with correct values.
  - `fifo_level` returns to 0 after each byte.
